sample_serializer: RTL and testbench
====================================

SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

Interface
REQ-001 Parameter BCLK_DIV, default 4, is the number of clk cycles per bit-clock half period; legal values are >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4, is the number of sample-buffer entries; legal values are powers of two, >= 2.
REQ-003 clk  input  1  is the single system clock; all state SHALL be clocked on its rising edge.
REQ-004 rst  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-005 i_data  input  24  is a signed mixed sample, valid only while i_valid=1.
REQ-006 i_valid  input  1  is a one-cycle write strobe, driven by the mixer ready pulse.
REQ-007 o_bclk  output  1  is the serial bit clock.
REQ-008 o_lrck  output  1  is the word select: 0 = left, 1 = right.
REQ-009 o_sdata  output  1  is the serial data, MSB first.
REQ-010 o_full  output  1  SHALL be 1 while the FIFO holds FIFO_DEPTH entries.
REQ-011 o_empty  output  1  SHALL be 1 while the FIFO holds 0 entries.
REQ-012 o_overflow  output  1  is a one-cycle pulse when a write is dropped.
REQ-013 o_underrun  output  1  is a one-cycle pulse when a frame starts with the FIFO empty.

Function
REQ-014 Bit clock: a divider counting 0..BCLK_DIV-1 SHALL toggle o_bclk on the cycle after its terminal count, giving period 2*BCLK_DIV clk cycles and rising edges at cycle BCLK_DIV, 3*BCLK_DIV, and so on after reset release.
REQ-015 Slot counter: a 6-bit counter 0..63 SHALL advance on each o_bclk falling transition and wrap 63->0; it resets to 63, so the first falling edge enters slot 0.
REQ-016 Word select: o_lrck SHALL be 0 for slots 0-31 and 1 for slots 32-63, updated on the same falling transition as the slot counter.
REQ-017 Sample fetch: on entry to slot 0, if o_empty=0, the head entry SHALL be popped into a 24-bit shift register.
REQ-018 Sample fetch (empty): on entry to slot 0, if o_empty=1, the shift register SHALL load 24'h000000 and o_underrun SHALL pulse for exactly one clk cycle.
REQ-019 Data format: o_sdata SHALL carry shift-register bit 23-k in slots 1+k and 33+k for k=0..23, and 0 in slots 0, 25-32 and 57-63.
REQ-020 Mono duplication: the same popped sample SHALL be sent on both channels; the register is reloaded from the saved sample at slot 32, not re-popped.
REQ-021 o_sdata and o_lrck SHALL change only in the clk cycle where o_bclk goes 1->0, so they are stable at every rising edge.
REQ-022 Write: i_valid=1 with o_full=0 SHALL store i_data at the tail; the entry is visible (o_empty=0) on the next cycle.
REQ-023 Write when full: i_valid=1 with o_full=1 and no pop in the same cycle SHALL drop i_data, leave the FIFO unchanged and pulse o_overflow for one cycle.
REQ-024 Simultaneous push and pop when full SHALL accept the write; occupancy is unchanged and o_overflow stays 0.
REQ-025 Simultaneous push and pop when empty SHALL be treated as empty for the pop: zeros are sent, o_underrun pulses, and the write is stored.
REQ-026 Pointers SHALL be log2(FIFO_DEPTH) bits wide with an extra wrap bit, wrapping modulo 2*FIFO_DEPTH; full and empty SHALL be derived from them combinationally.
REQ-027 The block SHALL not modify sample values: no scaling, no saturation, and bit-exact two's complement output.

Reset
REQ-028 While rst=1 the outputs SHALL be o_bclk=0, o_lrck=0, o_sdata=0, o_full=0, o_empty=1, o_overflow=0, o_underrun=0.
REQ-029 While rst=1 the internal state SHALL be: divider=0, slot=63, pointers=0, shift register and saved sample = 0.
REQ-030 Reset asserted mid-frame SHALL discard all buffered samples and the partial frame immediately, without waiting for a clock edge.
REQ-031 After rst deasserts, timing SHALL restart per REQ-014/015, and the first o_bclk rise SHALL occur exactly BCLK_DIV clk cycles later.

Verification
REQ-032 Write 24'h800001 once, then idle -> left slots 1-24 and right slots 33-56 carry 1000...0001; the next frame has o_underrun pulse and all-zero data.
REQ-033 Hold the FIFO empty from reset -> o_underrun pulses once per frame (every 128*BCLK_DIV = 512 clk cycles) and o_sdata stays 0.
REQ-034 Burst-write 5 samples in 5 cycles with FIFO_DEPTH=4 and no pop -> o_full=1 after the 4th write; the 5th is dropped with a one-cycle o_overflow; frames output samples 1-4 in order.
REQ-035 Push on the exact cycle of a slot-0 pop while full -> write accepted, o_overflow=0, and occupancy stays 4.
REQ-036 Assert rst at slot 40 with 3 entries buffered -> all outputs at reset values immediately; after release o_empty=1 and the first o_bclk rise comes 4 cycles later.
REQ-037 Check o_bclk period = 8 clk cycles, and that o_lrck/o_sdata are stable across every rising edge for BCLK_DIV=4 and BCLK_DIV=2.

Source files
------------

// File: rtl/sample_serializer.sv
// sample_serializer: buffers signed 24-bit mono samples in a small FIFO and
// shifts each one out MSB-first on both channels of a 64-slot serial audio
// frame, generating the bit clock and word select locally from clk.
module sample_serializer #(
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] i_data,
    input  logic        i_valid,
    output logic        o_bclk,
    output logic        o_lrck,
    output logic        o_sdata,
    output logic        o_full,
    output logic        o_empty,
    output logic        o_overflow,
    output logic        o_underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(BCLK_DIV);

    logic [DW-1:0] div;
    logic [5:0]    slot;
    logic [5:0]    next_slot;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [23:0]   shreg;
    logic [23:0]   saved;
    logic [23:0]   head;
    logic          div_tc;
    logic          bclk_fall;
    logic          fetch;
    logic          pop;
    logic          push;
    logic          data_slot;

    // The extra wrap bit distinguishes a full FIFO from an empty one when the
    // address bits of both pointers coincide.
    assign o_empty   = (wr_ptr == rd_ptr);
    assign o_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign div_tc    = (div == DW'(BCLK_DIV - 1));
    assign bclk_fall = div_tc && o_bclk;
    assign next_slot = slot + 6'd1;
    assign fetch     = bclk_fall && (next_slot == 6'd0);
    assign pop       = fetch && !o_empty;
    // A pop in the same cycle frees a slot, so a write while full is still accepted.
    assign push      = i_valid && (!o_full || pop);
    assign head      = mem[rd_ptr[AW-1:0]];
    // Slots 1..24 of each half carry data; the low five bits are the same for both halves.
    assign data_slot = (next_slot[4:0] >= 5'd1) && (next_slot[4:0] <= 5'd24);

    // Bit-clock divider: toggle o_bclk each time the divider wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div    <= '0;
            o_bclk <= 1'b0;
        end else if (div_tc) begin
            div    <= '0;
            o_bclk <= ~o_bclk;
        end else begin
            div    <= div + DW'(1);
        end
    end

    // FIFO pointers and the dropped-write indicator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            o_overflow <= i_valid && o_full && !pop;
        end
    end

    // Sample storage; contents are meaningless until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Frame sequencer: slot count, word select, sample fetch and serial shift,
    // all updated only on the bit-clock falling transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot       <= 6'd63;
            o_lrck     <= 1'b0;
            o_sdata    <= 1'b0;
            shreg      <= '0;
            saved      <= '0;
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= 1'b0;
            if (bclk_fall) begin
                slot   <= next_slot;
                o_lrck <= next_slot[5];
                if (next_slot == 6'd0) begin
                    o_sdata <= 1'b0;
                    if (!o_empty) begin
                        shreg <= head;
                        saved <= head;
                    end else begin
                        shreg      <= '0;
                        saved      <= '0;
                        o_underrun <= 1'b1;
                    end
                end else if (next_slot == 6'd32) begin
                    o_sdata <= 1'b0;
                    shreg   <= saved;
                end else if (data_slot) begin
                    o_sdata <= shreg[23];
                    shreg   <= {shreg[22:0], 1'b0};
                end else begin
                    o_sdata <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_serializer.sv
// Testbench for sample_serializer: directed writes with hand-computed frame
// contents, checked by a scoreboard monitor that decodes the serial stream.
module tb_sample_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] i_data;
    logic        i_valid;
    logic        o_bclk, o_lrck, o_sdata, o_full, o_empty, o_overflow, o_underrun;
    logic        b2_bclk, b2_lrck, b2_sdata, b2_full, b2_empty, b2_overflow, b2_underrun;

    typedef struct {
        logic [23:0] sample;
        logic        underrun;
    } exp_t;

    exp_t        expq[$];
    int          nchecks = 0;
    int          npass   = 0;
    int          cyc;

    sample_serializer #(.BCLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_bclk(o_bclk), .o_lrck(o_lrck), .o_sdata(o_sdata),
        .o_full(o_full), .o_empty(o_empty),
        .o_overflow(o_overflow), .o_underrun(o_underrun)
    );

    sample_serializer #(.BCLK_DIV(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_bclk(b2_bclk), .o_lrck(b2_lrck), .o_sdata(b2_sdata),
        .o_full(b2_full), .o_empty(b2_empty),
        .o_overflow(b2_overflow), .o_underrun(b2_underrun)
    );

    always #5 clk = ~clk;

    // Cycle count since the last reset release: posedge n sets cyc to n.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nchecks++;
        if (actual === expected) npass++;
        else $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    endtask

    // Scoreboard monitor state for the BCLK_DIV=4 instance.
    int          mslot = 63;
    bit          in_frame = 0;
    exp_t        cur;
    logic [23:0] left_w, right_w;
    int          pad_err, lrck_err, ucnt;
    logic        p_bclk = 0, p_lrck = 0, p_sdata = 0;
    int          stab_err = 0, per_err = 0, per_cnt = 0;
    longint      ncnt = 0, last_rise = -1;

    task automatic finishFrame();
        checkOutput("frame_left", left_w, cur.sample);
        checkOutput("frame_right", right_w, cur.sample);
        checkOutput("frame_pad_zero", pad_err, 0);
        checkOutput("frame_lrck", lrck_err, 0);
        checkOutput("frame_underrun", ucnt, cur.underrun ? 1 : 0);
    endtask

    // Decode the serial stream on each bit-clock edge and compare whole frames.
    always @(negedge clk) begin
        ncnt++;
        if (rst) begin
            mslot = 63; in_frame = 0; p_bclk = 0; p_lrck = 0; p_sdata = 0; last_rise = -1;
        end else begin
            automatic bit rise = o_bclk && !p_bclk;
            automatic bit fall = !o_bclk && p_bclk;
            if (rise) begin
                if (o_lrck !== p_lrck || o_sdata !== p_sdata) stab_err++;
                if (last_rise >= 0) begin
                    per_cnt++;
                    if (ncnt - last_rise != 8) per_err++;
                end
                last_rise = ncnt;
            end
            if (fall) begin
                mslot = (mslot + 1) % 64;
                if (mslot == 0) begin
                    if (in_frame) finishFrame();
                    in_frame = 0;
                    if (expq.size() > 0) begin
                        cur = expq.pop_front();
                        in_frame = 1; left_w = 0; right_w = 0;
                        pad_err = 0; lrck_err = 0; ucnt = 0;
                    end
                end
            end
            if (in_frame && o_underrun) ucnt++;
            if (rise && in_frame) begin
                automatic int k = mslot % 32;
                if (o_lrck !== (mslot >= 32)) lrck_err++;
                if (k >= 1 && k <= 24) begin
                    if (mslot < 32) left_w[24-k] = o_sdata;
                    else            right_w[24-k] = o_sdata;
                end else if (o_sdata !== 1'b0) begin
                    pad_err++;
                end
            end
            p_bclk = o_bclk; p_lrck = o_lrck; p_sdata = o_sdata;
        end
    end

    // Bit-clock period and edge stability for the BCLK_DIV=2 instance.
    logic   q_bclk = 0, q_lrck = 0, q_sdata = 0;
    int     stab2_err = 0, per2_err = 0, per2_cnt = 0;
    longint n2 = 0, last2 = -1;
    always @(negedge clk) begin
        n2++;
        if (rst) begin
            q_bclk = 0; q_lrck = 0; q_sdata = 0; last2 = -1;
        end else begin
            if (b2_bclk && !q_bclk) begin
                if (b2_lrck !== q_lrck || b2_sdata !== q_sdata) stab2_err++;
                if (last2 >= 0) begin
                    per2_cnt++;
                    if (n2 - last2 != 4) per2_err++;
                end
                last2 = n2;
            end
            q_bclk = b2_bclk; q_lrck = b2_lrck; q_sdata = b2_sdata;
        end
    end

    task automatic waitCyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("sync_cycle", cyc, n);
    endtask

    // Drive one write so that it is sampled at posedge number n.
    task automatic applyStimulus(input int n, input logic [23:0] data);
        waitCyc(n - 1);
        i_valid = 1'b1;
        i_data  = data;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    initial begin
        automatic logic [23:0] burst [5] = '{24'h123456, 24'hFEDCBA, 24'h7FFFFF, 24'h000001, 24'hABCDEF};
        i_valid = 1'b0;
        i_data  = '0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {o_bclk, o_lrck, o_sdata, o_full, o_empty, o_overflow, o_underrun}, 7'b0000100);
        rst = 1'b0;

        // One sample, then idle frames: first frame carries it, later frames underrun.
        expq.push_back('{24'h800001, 1'b0});
        expq.push_back('{24'h000000, 1'b1});
        expq.push_back('{24'h000000, 1'b1});
        applyStimulus(2, 24'h800001);
        checkOutput("empty_after_write", o_empty, 1'b0);

        // Burst of five while nothing is popped: fifth is dropped.
        waitCyc(1099);
        for (int i = 0; i < 5; i++) begin
            i_valid = 1'b1;
            i_data  = burst[i];
            @(negedge clk);
            if (i == 2) checkOutput("full_after_3", o_full, 1'b0);
            if (i == 3) begin
                checkOutput("full_after_4", o_full, 1'b1);
                checkOutput("no_overflow_4", o_overflow, 1'b0);
            end
            if (i == 4) checkOutput("overflow_5", o_overflow, 1'b1);
        end
        i_valid = 1'b0;
        @(negedge clk);
        checkOutput("overflow_one_cycle", o_overflow, 1'b0);
        checkOutput("still_full", o_full, 1'b1);
        for (int i = 0; i < 4; i++) expq.push_back('{burst[i], 1'b0});

        // Write on the exact cycle of the slot-0 pop while full.
        applyStimulus(1544, 24'h800000);
        checkOutput("push_pop_full_overflow", o_overflow, 1'b0);
        checkOutput("push_pop_full_full", o_full, 1'b1);
        expq.push_back('{24'h800000, 1'b0});
        expq.push_back('{24'h000000, 1'b1});

        // Write on the slot-0 fetch cycle while empty: frame underruns, write kept.
        applyStimulus(4104, 24'h5A5A5A);
        checkOutput("push_pop_empty_stored", o_empty, 1'b0);
        expq.push_back('{24'h5A5A5A, 1'b0});
        expq.push_back('{24'h000000, 1'b1});

        // Buffer three samples, then reset in the right half of the frame.
        applyStimulus(5200, 24'h111111);
        applyStimulus(5201, 24'h222222);
        applyStimulus(5202, 24'h333333);
        waitCyc(5450);
        checkOutput("pre_reset_empty", o_empty, 1'b0);
        checkOutput("pre_reset_lrck", o_lrck, 1'b1);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset_outputs",
                       {o_bclk, o_lrck, o_sdata, o_full, o_empty, o_overflow, o_underrun}, 7'b0000100);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("post_reset_empty", o_empty, 1'b1);
        expq.push_back('{24'h000000, 1'b1});
        expq.push_back('{24'h000000, 1'b1});
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checkOutput("first_bclk_rise", o_bclk, (i == 4) ? 1'b1 : 1'b0);
        end

        begin
            int g = 0;
            while ((expq.size() > 0 || in_frame) && g < 3000) begin
                @(negedge clk);
                g++;
            end
        end
        checkOutput("scoreboard_drained", expq.size() + int'(in_frame), 0);
        checkOutput("bclk_period_div4", per_err, 0);
        checkOutput("bclk_measured_div4", per_cnt > 0, 1'b1);
        checkOutput("edge_stable_div4", stab_err, 0);
        checkOutput("bclk_period_div2", per2_err, 0);
        checkOutput("bclk_measured_div2", per2_cnt > 0, 1'b1);
        checkOutput("edge_stable_div2", stab2_err, 0);

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule
